sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Single-clock, parametrised FIFO for in-domain buffering between pipeline stages, such as after the CDC FIFO on the consumer side.
- Generalised in WIDTH and DEPTH.
- Adds an occupancy count, programmable almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags.
- Read data is registered: one-cycle read latency, qualified by rvalid.
- Storage is a flip-flop register array.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 64, number of entries; must be a power of 2, ≥ 2.
- AFULL_TH, DEPTH-4, afull asserts when count ≥ AFULL_TH.
- AEMPTY_TH, 4, aempty asserts when count ≤ AEMPTY_TH.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush.
- winc  in  1  write request.
- wdata  in  WIDTH  write data.
- wfull  out  1  FIFO full.
- rinc  in  1  read request.
- rdata  out  WIDTH  read data, valid when rvalid.
- rvalid  out  1  rdata holds a newly popped word this cycle.
- rempty  out  1  FIFO empty.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- afull  out  1  almost full.
- aempty  out  1  almost empty.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - wptr = rptr = 0, count = 0.
  - rempty = 1, wfull = 0, aempty = 1, afull = 0.
  - rvalid = 0, rdata = 0.
  - overflow = underflow = 0.
  - Memory contents are not reset.
- Pointers are binary, $clog2(DEPTH)+1 bits.
  - Low bits address the array; the MSB is the wrap bit.
  - Increments wrap modulo 2*DEPTH.
  - full = (addr bits equal) and (MSBs differ); empty = (pointers equal).
- Accept rules:
  - wr_ok = winc & ~wfull.
  - rd_ok = rinc & ~rempty.
  - Flags are evaluated on current registered state; there is no same-cycle bypass.
  - A write while full is dropped and sets overflow.
  - A read while empty is dropped and sets underflow.
- Write: on wr_ok, mem[wptr] <= wdata and wptr++.
- Read latency 1: on rd_ok, rdata <= mem[rptr], rptr++, and rvalid = 1 next cycle.
  - Otherwise rvalid = 0 next cycle and rdata holds its value.
- count_next = count + wr_ok − rd_ok. Simultaneous write and read (non-empty, non-full) leaves count unchanged.
- wfull, rempty, afull and aempty are registers computed from count_next and the next pointers, so they are exact in the cycle after the edge.
- Full boundary: simultaneous winc+rinc while full → only the read is accepted; count goes to DEPTH−1 and wfull deasserts next cycle.
- Empty boundary: simultaneous winc+rinc while empty → only the write is accepted; rvalid stays 0 and count goes to 1.
- Flush: clear has priority over winc/rinc.
  - Next cycle: pointers = 0, count = 0, rempty = 1, aempty = 1, wfull = afull = 0.
  - rvalid = 0; overflow and underflow are cleared; rdata holds.
- Reset mid-operation: all state returns immediately to reset values.
- Error flags are sticky until clear or reset.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - rdata continuously presents the head word, mem[rptr], through a registered prefetch stage.
  - rvalid = ~rempty; rinc acts as a pop acknowledge.
  - A word written into an empty FIFO appears on rdata with rvalid = 1 one cycle after the write edge.
  - rempty/count semantics are unchanged.
- Undefined: the standard one-cycle-latency read described in Behaviour.

Decomposition:
- Shared constants header (sync_fifo_defs.vh):
  - ADDR_W = $clog2(DEPTH) and CNT_W = ADDR_W+1 derivation macros.
  - Default threshold values.
- Sub-module sync_fifo_mem:
  - Simple dual-port register array (one write port, one registered read port).
  - Parametrised WIDTH/DEPTH.
  - Isolated so it can later be swapped for an SRAM macro.
- Pointer, count and flag logic stays in the top module.

Test Plan:
- Reset, then write 64 words 0..63 → count = 64, wfull = 1, afull asserted from count = 60 onward; 65th winc → word dropped, overflow = 1.
- Read all 64 words → rdata sequence 0..63, each one cycle after rinc with rvalid = 1; rempty = 1 after the last; next rinc → underflow = 1, rvalid = 0.
- At count = 64, assert winc+rinc in one cycle → count = 63, wfull = 0, rdata = head word; when empty, winc+rinc → count = 1, rvalid = 0.
- Pointer wrap: 200 continuous writes/reads with count held between 1 and 10 → data order preserved across three wraps; aempty tracks count ≤ 4.
- Flush: fill 20 words, pulse clear with winc = 1 → count = 0, rempty = 1, overflow = 0, and the concurrent write is discarded; assert rst_n low mid-burst → all outputs return to reset values asynchronously.
- With SYNC_FIFO_FWFT_EN: write 0xA5A5A5A5 into an empty FIFO → rdata = 0xA5A5A5A5 with rvalid = 1 one cycle later, without rinc.

Source files
------------

// File: rtl/sync_fifo_param_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds the default parameter values, the address/count width derivation
// and the packed status-flag bundle used by sync_fifo_param.
package sync_fifo_param_pkg;

    // Default geometry and thresholds.
    localparam int unsigned DEF_WIDTH        = 32;
    localparam int unsigned DEF_DEPTH        = 64;
    localparam int unsigned DEF_AFULL_MARGIN = 4;   // afull threshold = DEPTH - margin
    localparam int unsigned DEF_AEMPTY_TH    = 4;

    // Address width for a power-of-two depth; never returns 0 so that the
    // pointer always has at least one address bit below the wrap bit.
    function automatic int unsigned fifo_addr_w(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Pointer / count width: one extra bit over the address (wrap bit).
    function automatic int unsigned fifo_cnt_w(input int unsigned depth);
        return fifo_addr_w(depth) + 1;
    endfunction

    // Registered status flags, all derived from next-state count/pointers.
    typedef struct packed {
        logic wfull;
        logic rempty;
        logic afull;
        logic aempty;
    } fifo_stat_t;

    localparam fifo_stat_t FIFO_STAT_RST = '{
        wfull  : 1'b0,
        rempty : 1'b1,
        afull  : 1'b0,
        aempty : 1'b1
    };

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port flip-flop array: one write port, one registered read port.
// Latency: read data appears on rdata_o one cycle after re_i.
// Backpressure: none; the owner guarantees legal accesses.
//
// Ports:
//   clk, rst_n          clock and async active-low reset (read register only)
//   we_i/waddr_i/wdata_i write port
//   re_i/raddr_i         read request and address
//   rdata_o              registered read data, holds when re_i is low
//
// A same-cycle read and write of one address returns the new write data.
// The array itself is not reset so it can be swapped for an SRAM macro.
module sync_fifo_mem
    import sync_fifo_param_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    localparam int unsigned ADDR_W = fifo_addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Write-first forwarding: the array update and the read register load
    // happen on the same edge, so a colliding read must take wdata_i.
    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            if (we_i && (waddr_i == raddr_i)) begin
                rdata_d = wdata_i;
            end else begin
                rdata_d = mem_q[raddr_i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with count, almost-full/empty, flush, sticky errors.
// Latency: 1 cycle from rinc to rdata/rvalid (FWFT build: head word always presented).
// Backpressure: writes dropped while wfull (sets overflow), reads dropped while rempty (sets underflow).
//
// Ports:
//   clk, rst_n     clock, async active-low reset
//   clear          synchronous flush, priority over winc/rinc
//   winc, wdata    write request and data; wfull reports full
//   rinc           read request (pop acknowledge in FWFT build)
//   rdata, rvalid  read data and its qualifier; rempty reports empty
//   count          occupancy 0..DEPTH
//   afull, aempty  count >= AFULL_TH / count <= AEMPTY_TH
//   overflow       sticky: write attempted while full
//   underflow      sticky: read attempted while empty
//
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
// DEPTH must be a power of two and at least 2.
module sync_fifo_param
    import sync_fifo_param_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned AFULL_TH  = DEPTH - DEF_AFULL_MARGIN,
    parameter int unsigned AEMPTY_TH = DEF_AEMPTY_TH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   winc,
    input  logic [WIDTH-1:0]       wdata,
    output logic                   wfull,
    input  logic                   rinc,
    output logic [WIDTH-1:0]       rdata,
    output logic                   rvalid,
    output logic                   rempty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   afull,
    output logic                   aempty,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int unsigned ADDR_W = fifo_addr_w(DEPTH);
    localparam int unsigned CNT_W  = fifo_cnt_w(DEPTH);

    localparam logic [CNT_W-1:0] AFULL_LIM  = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0] AEMPTY_LIM = CNT_W'(AEMPTY_TH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    fifo_stat_t       stat_q, stat_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    // Accept decisions use registered flags only; no same-cycle bypass.
    logic wr_ok, rd_ok;
    logic wr_en, rd_en;

    assign wr_ok = winc & ~stat_q.wfull;
    assign rd_ok = rinc & ~stat_q.rempty;

    // Flush wins over both ports.
    assign wr_en = wr_ok & ~clear;
    assign rd_en = rd_ok & ~clear;

    // ------------------------------------------------------------------
    // Next-state pointers, count and flags
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] wr_inc, rd_inc;

    assign wr_inc = {{(CNT_W-1){1'b0}}, wr_en};
    assign rd_inc = {{(CNT_W-1){1'b0}}, rd_en};

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        stat_d  = stat_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;

        if (clear) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            stat_d  = FIFO_STAT_RST;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            // Pointers wrap modulo 2*DEPTH through natural CNT_W overflow.
            wptr_d  = wptr_q + wr_inc;
            rptr_d  = rptr_q + rd_inc;
            count_d = count_q + wr_inc - rd_inc;

            // Full: same slot, opposite lap. Empty: identical pointers.
            stat_d.wfull  = (wptr_d[ADDR_W-1:0] == rptr_d[ADDR_W-1:0]) &&
                            (wptr_d[ADDR_W] != rptr_d[ADDR_W]);
            stat_d.rempty = (wptr_d == rptr_d);
            stat_d.afull  = (count_d >= AFULL_LIM);
            stat_d.aempty = (count_d <= AEMPTY_LIM);

            ovf_d = ovf_q | (winc & stat_q.wfull);
            udf_d = udf_q | (rinc & stat_q.rempty);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            stat_q  <= FIFO_STAT_RST;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            stat_q  <= stat_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage and read path
    // ------------------------------------------------------------------
    logic              mem_re;
    logic [ADDR_W-1:0] mem_raddr;
    logic [WIDTH-1:0]  mem_rdata;

`ifdef SYNC_FIFO_FWFT_EN
    // Prefetch register tracks the head of the next cycle: it reloads from
    // the next read pointer every cycle, so a pop advances to the following
    // word and a write into an empty FIFO is forwarded straight in.
    // During a flush the register simply holds.
    assign mem_re    = ~clear;
    assign mem_raddr = rptr_d[ADDR_W-1:0];
    assign rvalid    = ~stat_q.rempty;
`else
    logic rvalid_q, rvalid_d;

    assign mem_re    = rd_en;
    assign mem_raddr = rptr_q[ADDR_W-1:0];
    assign rvalid_d  = rd_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rvalid_d;
        end
    end

    assign rvalid = rvalid_q;
`endif

    sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (wr_en),
        .waddr_i (wptr_q[ADDR_W-1:0]),
        .wdata_i (wdata),
        .re_i    (mem_re),
        .raddr_i (mem_raddr),
        .rdata_o (mem_rdata)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rdata     = mem_rdata;
    assign count     = count_q;
    assign wfull     = stat_q.wfull;
    assign rempty    = stat_q.rempty;
    assign afull     = stat_q.afull;
    assign aempty    = stat_q.aempty;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (default 32x64 geometry).
// A queue model tracks FIFO contents and flags; popped words go to a
// scoreboard queue and are compared when the DUT presents them.
module tb_sync_fifo_param;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned AF_TH = DEPTH - 4;
    localparam int unsigned AE_TH = 4;

    logic             clk;
    logic             rst_n;
    logic             clear;
    logic             winc;
    logic [WIDTH-1:0] wdata;
    logic             wfull;
    logic             rinc;
    logic [WIDTH-1:0] rdata;
    logic             rvalid;
    logic             rempty;
    logic [6:0]       count;
    logic             afull;
    logic             aempty;
    logic             overflow;
    logic             underflow;

    sync_fifo_param #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AFULL_TH  (AF_TH),
        .AEMPTY_TH (AE_TH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .winc      (winc),
        .wdata     (wdata),
        .wfull     (wfull),
        .rinc      (rinc),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .rempty    (rempty),
        .count     (count),
        .afull     (afull),
        .aempty    (aempty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    logic [WIDTH-1:0] mq[$];     // FIFO contents, head at index 0
    logic [WIDTH-1:0] sb[$];     // popped words awaiting rdata
    logic [WIDTH-1:0] last_rd;   // value rdata must hold when no pop
    bit               ovf_m;
    bit               udf_m;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_count"},  count,     0);
        check({tag, "_wfull"},  wfull,     0);
        check({tag, "_rempty"}, rempty,    1);
        check({tag, "_afull"},  afull,     0);
        check({tag, "_aempty"}, aempty,    1);
        check({tag, "_rvalid"}, rvalid,    0);
        check({tag, "_rdata"},  rdata,     0);
        check({tag, "_ovf"},    overflow,  0);
        check({tag, "_udf"},    underflow, 0);
    endtask

    task automatic model_reset();
        mq.delete();
        sb.delete();
        last_rd = '0;
        ovf_m   = 1'b0;
        udf_m   = 1'b0;
    endtask

    // One clock cycle: drive inputs, update the model, step the edge,
    // then compare every output against the model.
    task automatic cyc(input bit w, input logic [WIDTH-1:0] d, input bit r, input bit c);
        bit               wok;
        bit               rok;
        logic [WIDTH-1:0] exp_d;
        winc  = w;
        wdata = d;
        rinc  = r;
        clear = c;
        wok = w && (mq.size() < DEPTH);
        rok = r && (mq.size() > 0);
        if (c) begin
            mq.delete();
            ovf_m = 1'b0;
            udf_m = 1'b0;
            wok   = 1'b0;
            rok   = 1'b0;
        end else begin
            if (w && !wok) ovf_m = 1'b1;
            if (r && !rok) udf_m = 1'b1;
            if (rok) sb.push_back(mq.pop_front());
            if (wok) mq.push_back(d);
        end
        @(posedge clk);
        #1;
        winc  = 1'b0;
        rinc  = 1'b0;
        clear = 1'b0;
`ifdef SYNC_FIFO_FWFT_EN
        if (rok) void'(sb.pop_front());
        check("rvalid", rvalid, mq.size() != 0);
        if (mq.size() != 0) check("rdata_head", rdata, mq[0]);
`else
        check("rvalid", rvalid, rok);
        if (rok) begin
            exp_d = sb.pop_front();
            check("rdata", rdata, exp_d);
            last_rd = exp_d;
        end else begin
            check("rdata_hold", rdata, last_rd);
        end
`endif
        check("count",     count,     mq.size());
        check("wfull",     wfull,     mq.size() == DEPTH);
        check("rempty",    rempty,    mq.size() == 0);
        check("afull",     afull,     mq.size() >= AF_TH);
        check("aempty",    aempty,    mq.size() <= AE_TH);
        check("overflow",  overflow,  ovf_m);
        check("underflow", underflow, udf_m);
    endtask

    task automatic drain();
        for (int i = 0; i <= DEPTH && mq.size() > 0; i++) begin
            cyc(1'b0, '0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        int writes;
        bit w;
        bit r;
        int n;

        rst_n = 1'b1;
        clear = 1'b0;
        winc  = 1'b0;
        rinc  = 1'b0;
        wdata = '0;
        model_reset();

        // Reset asserted with a real falling edge, checked while held low.
        #2 rst_n = 1'b0;
        #1 check_reset("rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check_reset("post_rst");

        // Fill 0..63, then one dropped write sets overflow.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, WIDTH'(i), 1'b0, 1'b0);
        cyc(1'b1, 32'hDEAD_0065, 1'b0, 1'b0);

        // Read all 64 back in order, then one read on empty sets underflow.
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);

        // Empty boundary: only the write is accepted.
        cyc(1'b1, 32'h0000_1234, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1);

        // Full boundary: only the read is accepted, wfull drops.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, WIDTH'(100 + i), 1'b0, 1'b0);
        cyc(1'b1, 32'h0000_BEEF, 1'b1, 1'b0);
        drain();

        // Pointer wrap: 200 writes with occupancy held in 1..10.
        writes = 0;
        for (int it = 0; it < 5000 && writes < 200; it++) begin
            n = mq.size();
            w = (n < 10) && ((n == 0) || ($urandom_range(0, 3) != 0));
            r = (n > 1) && ($urandom_range(0, 3) != 0);
            if (w) writes++;
            cyc(w, WIDTH'(32'h0001_0000 + writes), r, 1'b0);
        end
        drain();

        // Word written into an empty FIFO, then popped.
        cyc(1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);

        // Flush: set underflow, fill 20, clear with a concurrent write.
        cyc(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b1, WIDTH'(32'h0002_0000 + i), 1'b0, 1'b0);
        cyc(1'b1, 32'h0000_0077, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, 32'h0000_0088, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a write burst.
        for (int i = 0; i < 10; i++) cyc(1'b1, WIDTH'(32'h0003_0000 + i), i[0], 1'b0);
        cyc(1'b1, 32'h0000_0099, 1'b1, 1'b0);
        winc  = 1'b1;
        wdata = 32'h0000_00AA;
        #2 rst_n = 1'b0;
        #1 check_reset("mid_rst");
        model_reset();
        @(negedge clk);
        winc  = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1 check_reset("mid_rst_rel");
        cyc(1'b1, 32'h0000_0055, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
